hazard_unit_mc: RTL and testbench

Hazard/forwarding controller for the 3-stage (IF, DX, MW) core, extended with a multi-cycle execution unit (MUL/DIV) that has its own write-back slot.
- Combinational forwarding and load-use detection against MW.
- Sequential scoreboard tracking one in-flight multi-cycle op: RAW/WAW/structural stalls and a write-back pulse.
- Multi-cycle branch flush counter.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/mc_scoreboard.sv | 81 ++++++++
 rtl/hazard_unit_mc.sv | 147 ++++++++++++++
 tb/tb_hazard_unit_mc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller of the
// 3-stage core and its multi-cycle (MUL/DIV) scoreboard.
package hazard_pkg;

  // MW write-back source select encodings
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // Operand source select driven to the DX operand muxes
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_MW = 2'b01,
    FWD_MC = 2'b10
  } fwd_sel_e;

  // Multi-cycle scoreboard occupancy
  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  // Wide enough for MC_LAT-1 up to 14 and BR_FLUSH-1 up to 2
  localparam int CNT_W   = 4;
  localparam int FLUSH_W = 2;

endpackage

// File: rtl/mc_scoreboard.sv
// Tracks the single in-flight multi-cycle op: occupancy, destination,
// countdown to write-back, and the write strobe for its result.
// Handshake: 'issue' is a one-cycle accept pulse; the op is taken at that
// clock edge and its result is strobed on wb_en_o exactly MC_LAT cycles later
// unless a younger MW write to the same register supersedes it.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [ADDR_W-1:0] rd_mw,
  input  logic              rf_en_mw,
  output mc_state_e         state_o,
  output logic              pending_o,
  output logic              wb_cycle_o,
  output logic              wb_en_o,
  output logic              hit_rs1_o,
  output logic              hit_rs2_o,
  output logic [ADDR_W-1:0] mc_rd_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);

  mc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              busy;

  // Scoreboard registers; reset discards any in-flight op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Next state: issue (also legal in the write-back cycle), countdown, retire
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    if (issue) begin
      state_d = MC_BUSY;
      cnt_d   = CNT_LOAD;
      rd_d    = issue_rd;
    end else if (state_q == MC_BUSY) begin
      if (cnt_q == '0) begin
        state_d = MC_IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Status and match outputs; mc_rd is held after retire until the next issue
  always_comb begin
    busy       = (state_q == MC_BUSY);
    pending_o  = busy && (cnt_q != '0);
    wb_cycle_o = busy && (cnt_q == '0);
    wb_en_o    = wb_cycle_o && !(rf_en_mw && (rd_mw == rd_q));
    hit_rs1_o  = rs1_used && busy && (rd_q == rs1) && (rs1 != '0);
    hit_rs2_o  = rs2_used && busy && (rd_q == rs2) && (rs2 != '0);
    state_o    = state_q;
    mc_rd_o    = rd_q;
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the IF/DX/MW core with a multi-cycle
// execution unit: MW forwarding and load-use stalls, multi-cycle RAW/WAW/
// structural stalls, and a branch flush that can span several cycles.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int MC_LAT   = 4,
  parameter int BR_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_dx,
  input  logic [ADDR_W-1:0] rs2_dx,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [ADDR_W-1:0] rd_dx,
  input  logic              rf_en_dx,
  input  logic              mc_start,
  input  logic [ADDR_W-1:0] rd_mw,
  input  logic              rf_en_mw,
  input  logic [1:0]        sel_wb_mw,
  input  logic              br_taken,
  output logic              stall_if,
  output logic              stall_dx,
  output logic              flush_dx,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              mc_busy,
  output logic              mc_wb_en,
  output logic [ADDR_W-1:0] mc_rd
);

  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(BR_FLUSH - 1);

  mc_state_e          sb_state;
  logic               sb_pending;
  logic               sb_wb_cycle;
  logic               sb_wb_en;
  logic               sb_hit_rs1;
  logic               sb_hit_rs2;
  logic [ADDR_W-1:0]  sb_rd;

  logic               hit_mw_rs1, hit_mw_rs2;
  logic               stall_lw, stall_mc, stall;
  logic               br_ok, mc_issue;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  fwd_sel_e           fwd_a, fwd_b;

  mc_scoreboard #(
    .ADDR_W (ADDR_W),
    .MC_LAT (MC_LAT)
  ) u_mc_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue      (mc_issue),
    .issue_rd   (rd_dx),
    .rs1        (rs1_dx),
    .rs2        (rs2_dx),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used),
    .rd_mw      (rd_mw),
    .rf_en_mw   (rf_en_mw),
    .state_o    (sb_state),
    .pending_o  (sb_pending),
    .wb_cycle_o (sb_wb_cycle),
    .wb_en_o    (sb_wb_en),
    .hit_rs1_o  (sb_hit_rs1),
    .hit_rs2_o  (sb_hit_rs2),
    .mc_rd_o    (sb_rd)
  );

  // Hazard detection, forwarding priority and branch masking
  always_comb begin
    hit_mw_rs1 = rs1_used && rf_en_mw && (rd_mw == rs1_dx) && (rs1_dx != '0);
    hit_mw_rs2 = rs2_used && rf_en_mw && (rd_mw == rs2_dx) && (rs2_dx != '0);

    stall_lw = (sel_wb_mw == WB_MEM) && (hit_mw_rs1 || hit_mw_rs2);

    // RAW on a pending result, WAW on the same destination, or a second issue
    stall_mc = ((sb_hit_rs1 || sb_hit_rs2) && sb_pending)
            || (rf_en_dx && sb_pending && (rd_dx == sb_rd) && (rd_dx != '0))
            || (mc_start && sb_pending);

    stall = stall_lw || stall_mc;

    // Branch operands are not trustworthy while stalled
    br_ok    = br_taken && !stall && !rst;
    mc_issue = mc_start && !stall && !rst;

    // MW is the younger producer, so it wins over the multi-cycle result
    fwd_a = FWD_RF;
    if (hit_mw_rs1) begin
      fwd_a = FWD_MW;
    end else if (sb_hit_rs1 && sb_wb_cycle) begin
      fwd_a = FWD_MC;
    end
    fwd_b = FWD_RF;
    if (hit_mw_rs2) begin
      fwd_b = FWD_MW;
    end else if (sb_hit_rs2 && sb_wb_cycle) begin
      fwd_b = FWD_MC;
    end
  end

  // Branch flush counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // A taken branch (re)loads the count; otherwise it drains toward zero
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (br_ok) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - 1'b1;
    end
  end

  // Output drive; everything is forced low while reset is held
  always_comb begin
    stall_if  = 1'b0;
    stall_dx  = 1'b0;
    flush_dx  = 1'b0;
    forward_a = FWD_RF;
    forward_b = FWD_RF;
    mc_busy   = 1'b0;
    mc_wb_en  = 1'b0;
    mc_rd     = '0;
    if (!rst) begin
      stall_if  = stall;
      stall_dx  = stall;
      flush_dx  = stall || br_ok || (flush_cnt_q != '0);
      forward_a = fwd_a;
      forward_b = fwd_b;
      mc_busy   = (sb_state == MC_BUSY);
      mc_wb_en  = sb_wb_en;
      mc_rd     = sb_rd;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (MC_LAT=4, BR_FLUSH=2). Each cycle the
// expected output bundle is queued when inputs are applied and compared at
// the following falling edge.
module tb_hazard_unit_mc;
  import hazard_pkg::*;

  localparam int ADDR_W = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [ADDR_W-1:0] rs1_dx, rs2_dx, rd_dx, rd_mw, mc_rd;
  logic              rs1_used, rs2_used, rf_en_dx, mc_start, rf_en_mw, br_taken;
  logic [1:0]        sel_wb_mw, forward_a, forward_b;
  logic              stall_if, stall_dx, flush_dx, mc_busy, mc_wb_en;

  hazard_unit_mc #(
    .ADDR_W   (ADDR_W),
    .MC_LAT   (4),
    .BR_FLUSH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_dx    (rs1_dx),
    .rs2_dx    (rs2_dx),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .rd_dx     (rd_dx),
    .rf_en_dx  (rf_en_dx),
    .mc_start  (mc_start),
    .rd_mw     (rd_mw),
    .rf_en_mw  (rf_en_mw),
    .sel_wb_mw (sel_wb_mw),
    .br_taken  (br_taken),
    .stall_if  (stall_if),
    .stall_dx  (stall_dx),
    .flush_dx  (flush_dx),
    .forward_a (forward_a),
    .forward_b (forward_b),
    .mc_busy   (mc_busy),
    .mc_wb_en  (mc_wb_en),
    .mc_rd     (mc_rd)
  );

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (stall_if,stall_dx,flush,fa,fb,busy,wb,rd)",
               tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic st, input logic fl, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic busy, input logic wb,
                                     input logic [4:0] rd);
    return {st, st, fl, fa, fb, busy, wb, rd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    rs1_dx = '0; rs2_dx = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    rd_dx = '0; rf_en_dx = 1'b0; mc_start = 1'b0;
    rd_mw = '0; rf_en_mw = 1'b0; sel_wb_mw = WB_ALU; br_taken = 1'b0;
  endtask

  task automatic issue_mc(input logic [4:0] rd);
    clear_in();
    mc_start = 1'b1; rd_dx = rd; rf_en_dx = 1'b1;
  endtask

  // Queue the expectation for the inputs just applied, compare mid-cycle,
  // then move to just after the next rising edge for the next stimulus.
  task automatic step(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    exp_q.push_back(exp);
    @(negedge clk);
    obs = {stall_if, stall_dx, flush_dx, forward_a, forward_b, mc_busy, mc_wb_en, mc_rd};
    check_eq(tag, obs, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with hazards present on the inputs: outputs must stay low
    rst = 1'b1;
    clear_in();
    sel_wb_mw = WB_MEM; rf_en_mw = 1'b1; rd_mw = 5'd5; rs1_dx = 5'd5; rs1_used = 1'b1;
    mc_start = 1'b1; rd_dx = 5'd3; br_taken = 1'b1;
    step("rst_outs0", 14'd0);
    step("rst_outs1", 14'd0);
    rst = 1'b0;
    clear_in();
    step("post_rst_idle", 14'd0);

    // Load-use with a taken branch in the same cycle (branch masked)
    sel_wb_mw = WB_MEM; rf_en_mw = 1'b1; rd_mw = 5'd5; rs1_dx = 5'd5; rs1_used = 1'b1;
    br_taken = 1'b1;
    step("lu_stall", mk(1, 1, FWD_MW, FWD_RF, 0, 0, 0));
    clear_in();
    step("lu_br_masked", 14'd0);
    sel_wb_mw = WB_MEM; rf_en_mw = 1'b1; rd_mw = 5'd0; rs1_dx = 5'd0; rs1_used = 1'b1;
    step("lu_x0", 14'd0);

    // Plain ALU forwarding on rs2, then the same with rs2 unused
    clear_in();
    rf_en_mw = 1'b1; rd_mw = 5'd3; rs2_dx = 5'd3; rs2_used = 1'b1;
    step("fwd_b_mw", mk(0, 0, FWD_RF, FWD_MW, 0, 0, 0));
    rs2_used = 1'b0;
    step("fwd_b_unused", 14'd0);

    // Multi-cycle RAW: issue x7, consumer stalls three cycles then forwards
    issue_mc(5'd7);
    step("raw_issue", 14'd0);
    clear_in();
    rs1_dx = 5'd7; rs1_used = 1'b1;
    for (int i = 1; i <= 3; i++) step("raw_stall", mk(1, 1, FWD_RF, FWD_RF, 1, 0, 7));
    step("raw_wb", mk(0, 0, FWD_MC, FWD_RF, 1, 1, 7));
    step("raw_done", mk(0, 0, FWD_RF, FWD_RF, 0, 0, 7));

    // Structural: second issue waits until the write-back cycle
    issue_mc(5'd7);
    step("st_issue", mk(0, 0, FWD_RF, FWD_RF, 0, 0, 7));
    clear_in();
    step("st_c1", mk(0, 0, FWD_RF, FWD_RF, 1, 0, 7));
    issue_mc(5'd8);
    step("st_c2", mk(1, 1, FWD_RF, FWD_RF, 1, 0, 7));
    step("st_c3", mk(1, 1, FWD_RF, FWD_RF, 1, 0, 7));
    step("st_c4_accept", mk(0, 0, FWD_RF, FWD_RF, 1, 1, 7));
    clear_in();
    for (int i = 5; i <= 7; i++) step("st_busy2", mk(0, 0, FWD_RF, FWD_RF, 1, 0, 8));
    step("st_wb2_latency", mk(0, 0, FWD_RF, FWD_RF, 1, 1, 8));
    step("st_idle", mk(0, 0, FWD_RF, FWD_RF, 0, 0, 8));

    // WAW: unrelated destination passes, same destination stalls
    issue_mc(5'd7);
    step("waw_issue", mk(0, 0, FWD_RF, FWD_RF, 0, 0, 8));
    clear_in();
    rf_en_dx = 1'b1; rd_dx = 5'd6;
    step("waw_other_rd", mk(0, 0, FWD_RF, FWD_RF, 1, 0, 7));
    rd_dx = 5'd7;
    step("waw_c2", mk(1, 1, FWD_RF, FWD_RF, 1, 0, 7));
    step("waw_c3", mk(1, 1, FWD_RF, FWD_RF, 1, 0, 7));
    step("waw_c4", mk(0, 0, FWD_RF, FWD_RF, 1, 1, 7));
    clear_in();
    step("waw_idle", mk(0, 0, FWD_RF, FWD_RF, 0, 0, 7));

    // Write-back conflict: younger MW write to x9 suppresses mc_wb_en
    issue_mc(5'd9);
    step("wbc_issue", mk(0, 0, FWD_RF, FWD_RF, 0, 0, 7));
    clear_in();
    for (int i = 1; i <= 3; i++) step("wbc_busy", mk(0, 0, FWD_RF, FWD_RF, 1, 0, 9));
    rf_en_mw = 1'b1; rd_mw = 5'd9; rs1_dx = 5'd9; rs1_used = 1'b1;
    step("wbc_drop", mk(0, 0, FWD_MW, FWD_RF, 1, 0, 9));
    clear_in();
    step("wbc_idle", mk(0, 0, FWD_RF, FWD_RF, 0, 0, 9));

    // Branch flush spans two cycles
    br_taken = 1'b1;
    step("br_c0", mk(0, 1, FWD_RF, FWD_RF, 0, 0, 9));
    clear_in();
    step("br_c1", mk(0, 1, FWD_RF, FWD_RF, 0, 0, 9));
    step("br_c2_off", 14'd0 | mk(0, 0, FWD_RF, FWD_RF, 0, 0, 9));

    // Back-to-back branches reload the count
    br_taken = 1'b1;
    step("br2_c0", mk(0, 1, FWD_RF, FWD_RF, 0, 0, 9));
    step("br2_c1", mk(0, 1, FWD_RF, FWD_RF, 0, 0, 9));
    clear_in();
    step("br2_reload", mk(0, 1, FWD_RF, FWD_RF, 0, 0, 9));
    step("br2_off", mk(0, 0, FWD_RF, FWD_RF, 0, 0, 9));

    // Reset with the counter at 2 discards the op; no late write strobe
    issue_mc(5'd12);
    step("rmid_issue", mk(0, 0, FWD_RF, FWD_RF, 0, 0, 9));
    clear_in();
    step("rmid_c1", mk(0, 0, FWD_RF, FWD_RF, 1, 0, 12));
    rst = 1'b1;
    rs1_dx = 5'd12; rs1_used = 1'b1;
    step("rmid_rst", 14'd0);
    rst = 1'b0;
    clear_in();
    for (int i = 0; i < 6; i++) step("rmid_no_wb", 14'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
